// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB with 2-bit saturating counters, plus lookup/hit statistics.
// Latency: prediction registered, valid one cycle after the request; updates land on the same edge.
// Backpressure: none; a lookup is accepted every cycle it is requested, and so is an update.

package bpu_pkg;
  localparam int ADDR_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic  predict_taken;
    addr_t predict_target;
    logic  btb_hit;
  } branch_prediction_t;

  typedef struct packed {
    logic  update_valid;
    addr_t pc;
    logic  is_branch;
    logic  is_jal;
    logic  is_jalr;
    logic  actual_taken;
    addr_t actual_target;
  } branch_update_t;
endpackage

module branch_predictor_unit
  import bpu_pkg::*;
#(
  parameter int         BTB_ENTRIES = 16,
  parameter logic [1:0] RESET_CTR   = 2'b01
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pred_req_i,
  input  addr_t              pred_pc_i,
  output logic               pred_valid_o,
  output branch_prediction_t prediction_o,
  input  branch_update_t     update_i,
  output logic [31:0]        lookup_cnt_o,
  output logic [31:0]        hit_cnt_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  // BTB storage, one slot per index
  logic       valid_q  [BTB_ENTRIES];
  tag_t       tag_q    [BTB_ENTRIES];
  addr_t      target_q [BTB_ENTRIES];
  logic [1:0] ctr_q    [BTB_ENTRIES];
  logic       uncond_q [BTB_ENTRIES];

  idx_t       l_idx;
  tag_t       l_tag;
  logic       l_hit;
  logic       l_taken;
  addr_t      l_target;

  idx_t       u_idx;
  tag_t       u_tag;
  logic       u_acc;
  logic       u_hit;
  logic       u_jump;
  logic [1:0] u_ctr_nxt;

  // Word-offset bits of the update PC never select anything
  logic       unused_upd_pc_lsb;
  assign unused_upd_pc_lsb = ^update_i.pc[1:0];

  // Lookup path: reads the table as it stands before this edge's update
  always_comb begin
    l_idx    = pred_pc_i[IDX_W+1:2];
    l_tag    = pred_pc_i[ADDR_WIDTH-1:IDX_W+2];
    l_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    l_taken  = l_hit && (uncond_q[l_idx] || ctr_q[l_idx][1]);
    l_target = l_taken ? target_q[l_idx] : pred_pc_i + 32'd4;
  end

  // Update decode and saturating counter step
  always_comb begin
    u_idx     = update_i.pc[IDX_W+1:2];
    u_tag     = update_i.pc[ADDR_WIDTH-1:IDX_W+2];
    u_acc     = update_i.update_valid &&
                (update_i.is_branch || update_i.is_jal || update_i.is_jalr);
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_jump    = update_i.is_jal || update_i.is_jalr;
    u_ctr_nxt = ctr_q[u_idx];
    if (update_i.actual_taken) begin
      if (ctr_q[u_idx] != 2'b11) u_ctr_nxt = ctr_q[u_idx] + 2'd1;
    end else begin
      if (ctr_q[u_idx] != 2'b00) u_ctr_nxt = ctr_q[u_idx] - 2'd1;
    end
  end

  // Table write: train on hit, allocate only on a taken miss
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= RESET_CTR;
        uncond_q[i] <= 1'b0;
      end
    end else if (u_acc) begin
      if (u_hit) begin
        ctr_q[u_idx]    <= u_ctr_nxt;
        uncond_q[u_idx] <= u_jump;
        if (update_i.actual_taken) target_q[u_idx] <= update_i.actual_target;
      end else if (update_i.actual_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= update_i.actual_target;
        ctr_q[u_idx]    <= 2'b10;
        uncond_q[u_idx] <= u_jump;
      end
    end
  end

  // Registered response; prediction holds between requests
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_valid_o <= 1'b0;
      prediction_o <= '0;
    end else begin
      pred_valid_o <= pred_req_i;
      if (pred_req_i) begin
        prediction_o.btb_hit        <= l_hit;
        prediction_o.predict_taken  <= l_taken;
        prediction_o.predict_target <= l_target;
      end
    end
  end

  // Saturating lookup and hit statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lookup_cnt_o <= '0;
      hit_cnt_o    <= '0;
    end else if (pred_req_i) begin
      if (lookup_cnt_o != 32'hFFFF_FFFF) lookup_cnt_o <= lookup_cnt_o + 32'd1;
      if (l_hit && (hit_cnt_o != 32'hFFFF_FFFF)) hit_cnt_o <= hit_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Bench for branch_predictor_unit: directed scenarios with literal expectations,
// then randomized lookups/updates/resets checked every cycle against a table model.
// Inputs driven #1 after the rising edge; outputs compared on the falling edge.

module tb_branch_predictor_unit;
  import bpu_pkg::*;

  localparam int N = 16;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               pred_req_i;
  addr_t              pred_pc_i;
  logic               pred_valid_o;
  branch_prediction_t prediction_o;
  branch_update_t     update_i;
  logic [31:0]        lookup_cnt_o;
  logic [31:0]        hit_cnt_o;

  always #5 clk_i = ~clk_i;

  branch_predictor_unit #(.BTB_ENTRIES(N), .RESET_CTR(2'b01)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pred_req_i   (pred_req_i),
    .pred_pc_i    (pred_pc_i),
    .pred_valid_o (pred_valid_o),
    .prediction_o (prediction_o),
    .update_i     (update_i),
    .lookup_cnt_o (lookup_cnt_o),
    .hit_cnt_o    (hit_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an array of BTB slots indexed by (pc/4) mod N
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];
  bit          m_unc [N];

  bit          e_valid;
  bit          e_hit;
  bit          e_taken;
  logic [31:0] e_target;
  longint      e_lk;
  longint      e_ht;
  bit          chk_on = 1'b0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  // kind: 0 none, 1 branch, 2 jal, 3 jalr, 4 valid but not a control-flow op
  function automatic branch_update_t mk(input int kind, input logic [31:0] pc,
                                        input bit tk, input logic [31:0] tgt);
    branch_update_t u;
    u               = '0;
    u.update_valid  = (kind != 0);
    u.is_branch     = (kind == 1);
    u.is_jal        = (kind == 2);
    u.is_jalr       = (kind == 3);
    u.pc            = pc;
    u.actual_taken  = tk;
    u.actual_target = tgt;
    return u;
  endfunction

  task automatic model_apply(input bit rst, input bit req, input logic [31:0] pc,
                             input branch_update_t u);
    int i;
    bit h;
    bit jump;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_v[k] = 0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 1; m_unc[k] = 0;
      end
      e_valid = 0; e_hit = 0; e_taken = 0; e_target = '0; e_lk = 0; e_ht = 0;
      return;
    end
    if (req) begin
      i        = idx_of(pc);
      h        = m_v[i] && (m_tag[i] == tag_of(pc));
      e_valid  = 1;
      e_hit    = h;
      e_taken  = h && (m_unc[i] || m_ctr[i] >= 2);
      e_target = e_taken ? m_tgt[i] : pc + 32'd4;
      if (e_lk < 64'hFFFF_FFFF) e_lk++;
      if (h && e_ht < 64'hFFFF_FFFF) e_ht++;
    end else begin
      e_valid = 0;
    end
    if (u.update_valid && (u.is_branch || u.is_jal || u.is_jalr)) begin
      i    = idx_of(u.pc);
      jump = u.is_jal || u.is_jalr;
      if (m_v[i] && m_tag[i] == tag_of(u.pc)) begin
        m_ctr[i] = u.actual_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                  : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (u.actual_taken) m_tgt[i] = u.actual_target;
        m_unc[i] = jump;
      end else if (u.actual_taken) begin
        m_v[i] = 1; m_tag[i] = tag_of(u.pc); m_tgt[i] = u.actual_target;
        m_ctr[i] = 2; m_unc[i] = jump;
      end
    end
  endtask

  task automatic step(input bit rst, input bit req, input logic [31:0] pc,
                      input branch_update_t u);
    rst_i      = rst;
    pred_req_i = req;
    pred_pc_i  = pc;
    update_i   = u;
    @(posedge clk_i);
    #1;
    model_apply(rst, req, pc, u);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk_i) begin
    if (chk_on) begin
      check("cyc_valid",  {31'd0, pred_valid_o},               {31'd0, e_valid});
      check("cyc_hit",    {31'd0, prediction_o.btb_hit},       {31'd0, e_hit});
      check("cyc_taken",  {31'd0, prediction_o.predict_taken}, {31'd0, e_taken});
      check("cyc_target", prediction_o.predict_target,         e_target);
      check("cyc_lookup", lookup_cnt_o,                        e_lk[31:0]);
      check("cyc_hits",   hit_cnt_o,                           e_ht[31:0]);
    end
  end

  branch_update_t noup;

  initial begin
    logic [31:0] pc;
    logic [31:0] base;
    noup = mk(0, 32'h0, 1'b0, 32'h0);

    step(1, 0, 0, noup);
    step(1, 0, 0, noup);
    chk_on = 1'b1;
    check("rst_valid",  {31'd0, pred_valid_o}, 32'd0);
    check("rst_pred",   prediction_o.predict_target, 32'd0);
    check("rst_lookup", lookup_cnt_o, 32'd0);
    check("rst_hits",   hit_cnt_o, 32'd0);

    // Cold lookup
    step(0, 1, 32'h100, noup);
    check("cold_valid",  {31'd0, pred_valid_o}, 32'd1);
    check("cold_hit",    {31'd0, prediction_o.btb_hit}, 32'd0);
    check("cold_taken",  {31'd0, prediction_o.predict_taken}, 32'd0);
    check("cold_target", prediction_o.predict_target, 32'h104);
    check("cold_lookup", lookup_cnt_o, 32'd1);
    check("cold_hits",   hit_cnt_o, 32'd0);

    // Allocate, then train down to strongly not-taken
    step(0, 0, 0, mk(1, 32'h100, 1, 32'h200));
    step(0, 1, 32'h100, noup);
    check("alloc_hit",    {31'd0, prediction_o.btb_hit}, 32'd1);
    check("alloc_taken",  {31'd0, prediction_o.predict_taken}, 32'd1);
    check("alloc_target", prediction_o.predict_target, 32'h200);
    step(0, 0, 0, mk(1, 32'h100, 0, 32'h0));
    step(0, 0, 0, mk(1, 32'h100, 0, 32'h0));
    step(0, 1, 32'h100, noup);
    check("nt_hit",    {31'd0, prediction_o.btb_hit}, 32'd1);
    check("nt_taken",  {31'd0, prediction_o.predict_taken}, 32'd0);
    check("nt_target", prediction_o.predict_target, 32'h104);

    // Aliasing index, different tag
    step(0, 1, 32'h140, noup);
    check("alias_miss", {31'd0, prediction_o.btb_hit}, 32'd0);
    step(0, 0, 0, mk(1, 32'h140, 1, 32'h300));
    step(0, 1, 32'h100, noup);
    check("evicted_miss", {31'd0, prediction_o.btb_hit}, 32'd0);
    step(0, 1, 32'h140, noup);
    check("replace_target", prediction_o.predict_target, 32'h300);

    // JAL stays taken regardless of counter
    step(0, 0, 0, mk(2, 32'h80, 1, 32'h400));
    for (int k = 0; k < 4; k++) step(0, 0, 0, mk(2, 32'h80, 0, 32'h0));
    step(0, 1, 32'h80, noup);
    check("jal_taken",  {31'd0, prediction_o.predict_taken}, 32'd1);
    check("jal_target", prediction_o.predict_target, 32'h400);

    // Same-cycle lookup and first update: read-before-write
    step(1, 0, 0, noup);
    step(0, 1, 32'h100, mk(1, 32'h100, 1, 32'h500));
    check("rbw_miss", {31'd0, prediction_o.btb_hit}, 32'd0);
    step(0, 1, 32'h100, noup);
    check("rbw_next_hit",    {31'd0, prediction_o.btb_hit}, 32'd1);
    check("rbw_next_target", prediction_o.predict_target, 32'h500);

    // Not-taken miss never allocates
    step(0, 0, 0, mk(1, 32'h20, 0, 32'h0));
    step(0, 1, 32'h20, noup);
    check("nt_noalloc", {31'd0, prediction_o.btb_hit}, 32'd0);

    // Reset mid-sequence, with a lookup in flight and an update coincident
    step(0, 1, 32'h100, noup);
    step(1, 1, 32'h100, mk(1, 32'h100, 1, 32'h600));
    check("midrst_valid",  {31'd0, pred_valid_o}, 32'd0);
    check("midrst_lookup", lookup_cnt_o, 32'd0);
    check("midrst_hits",   hit_cnt_o, 32'd0);
    step(0, 1, 32'h100, noup);
    check("midrst_miss",   {31'd0, prediction_o.btb_hit}, 32'd0);
    check("midrst_count",  lookup_cnt_o, 32'd1);

    // Fall-through wraps at the top of the address space, then holds
    step(0, 1, 32'hFFFF_FFFC, noup);
    check("wrap_target", prediction_o.predict_target, 32'h0);
    step(0, 0, 0, noup);
    check("hold_valid",  {31'd0, pred_valid_o}, 32'd0);
    check("hold_target", prediction_o.predict_target, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      base = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 : 32'h0;
      pc   = base | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), pc,
           mk(int'($urandom_range(0, 4)),
              base | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2),
              bit'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC));
    end

    @(negedge clk_i);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_unit.md
BRANCH_PREDICTOR_UNIT -- requirements
Module: branch_predictor_unit

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, number of direct-mapped BTB entries (power of 2, 4..256).
REQ-002 SHALL have parameter RESET_CTR, default 2'b01, initial 2-bit counter value (weakly not-taken).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port pred_req_i, input, 1, fetch lookup request valid.
REQ-006 SHALL have port pred_pc_i, input, addr_t, fetch PC to predict.
REQ-007 SHALL have port pred_valid_o, output, 1, prediction valid, one cycle after pred_req_i.
REQ-008 SHALL have port prediction_o, output, branch_prediction_t, predict_taken / predict_target / btb_hit.
REQ-009 SHALL have port update_i, input, branch_update_t, resolved-branch update from execute.
REQ-010 SHALL have port lookup_cnt_o, output, 32, count of accepted lookups.
REQ-011 SHALL have port hit_cnt_o, output, 32, count of lookups that hit the BTB.

Function
REQ-012 SHALL derive IDX_W = log2(BTB_ENTRIES), with index = pc[IDX_W+1:2] and tag = pc[ADDR_WIDTH-1:IDX_W+2].
REQ-013 SHALL store per entry: valid, tag, target (addr_t), 2-bit saturating counter, uncond flag.
REQ-014 SHALL register the lookup: the response to pred_req_i in cycle N appears in cycle N+1 with pred_valid_o=1; pred_valid_o=0 in cycles with no request in N.
REQ-015 SHALL set btb_hit = entry.valid && entry.tag == tag(pred_pc_i).
REQ-016 SHALL set predict_taken = btb_hit && (uncond || counter[1]).
REQ-017 SHALL set predict_target = entry.target when predict_taken, else pred_pc_i + 4 (modulo 2^ADDR_WIDTH; wraps at 0xFFFFFFFC -> 0x0).
REQ-018 SHALL hold prediction_o at its last value when pred_valid_o=0.
REQ-019 SHALL ignore update_i unless update_valid && (is_branch || is_jal || is_jalr).
REQ-020 On an accepted update whose index/tag hits: counter increments saturating at 2'b11 if actual_taken, decrements saturating at 2'b00 otherwise; target <= actual_target if actual_taken; uncond <= is_jal||is_jalr.
REQ-021 On an accepted update that misses and actual_taken=1: SHALL allocate (overwrite) the indexed entry: valid=1, new tag, target=actual_target, counter=2'b10, uncond=is_jal||is_jalr.
REQ-022 On an accepted update that misses and actual_taken=0: SHALL leave the entry unchanged (no allocation).
REQ-023 For an unconditional entry (uncond=1), the counter SHALL still be updated but SHALL not affect predict_taken.
REQ-024 Simultaneous lookup and update to the same index in one cycle: lookup SHALL return pre-update contents (read-before-write); the update takes effect for lookups from the next cycle.
REQ-025 lookup_cnt_o SHALL increment by 1 per pred_req_i; hit_cnt_o SHALL increment by 1 per request that hits; both saturate at 0xFFFFFFFF.

Reset
REQ-026 While rst_i=1 at a clock edge: all entries valid=0, counters=RESET_CTR, tags/targets=0, uncond=0.
REQ-027 Reset values: pred_valid_o=0, prediction_o all-zero, lookup_cnt_o=0, hit_cnt_o=0.
REQ-028 A pred_req_i or update_i coincident with rst_i=1 SHALL be discarded; a lookup issued the cycle before reset SHALL NOT produce pred_valid_o=1 after reset.

Verification
REQ-029 After reset, lookup pc=0x100 -> next cycle pred_valid_o=1, btb_hit=0, predict_taken=0, predict_target=0x104, lookup_cnt_o=1, hit_cnt_o=0.
REQ-030 Update pc=0x100 branch taken target 0x200, then lookup 0x100 -> btb_hit=1, predict_taken=1 (ctr 10), target=0x200; two not-taken updates -> ctr 00, lookup gives taken=0, target 0x104.
REQ-031 Allocate pc=0x100 (16 entries), then lookup pc=0x140 (same index, different tag) -> btb_hit=0; taken update at 0x140 target 0x300 replaces entry, then lookup 0x100 misses.
REQ-032 JAL update pc=0x80 target 0x400, then four not-taken updates -> lookup still predict_taken=1, target 0x400.
REQ-033 Same-cycle lookup and first taken update at pc=0x100 -> that lookup misses; lookup next cycle hits with target from update.
REQ-034 Not-taken update on a miss at pc=0x20 -> subsequent lookup btb_hit=0; rst_i asserted mid-sequence -> all entries miss and both counters read 0.
